// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register index type and write-back source encoding.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM, SRC_MUL} wb_src_t;

    // A source is busy while owned by a long-latency op or while its write is in flight.
    function automatic logic reg_busy(input reg_idx_t rs, input logic [NREG-1:0] pend,
                                      input logic we, input reg_idx_t port);
        return (rs != '0) && (pend[rs] || (we && port == rs));
    endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-destination tracker for long-latency ops with busy queries.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_set_valid,
    input  logic [REG_AW-1:0] i_set_rd,
    input  logic              i_clr_valid,
    input  logic [REG_AW-1:0] i_clr_rd,
    input  logic              i_wr_enable,
    input  logic [REG_AW-1:0] i_wr_port,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic [NREG-1:0]   o_pending
);
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_next;

    // Set is applied after clear so a newer issue keeps ownership of the register.
    always_comb begin
        w_next = r_pending;
        if (i_clr_valid && i_clr_rd != '0) w_next[i_clr_rd] = 1'b0;
        if (i_set_valid && i_set_rd != '0) w_next[i_set_rd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) r_pending <= '0;
        else       r_pending <= w_next;
    end

    assign o_pending  = r_pending;
    assign o_rs1_busy = reg_busy(i_rs1, r_pending, i_wr_enable, i_wr_port);
    assign o_rs2_busy = reg_busy(i_rs2, r_pending, i_wr_enable, i_wr_port);
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU, load and multiply results onto one registered register-file write port,
// ALU first, load/multiply round-robin, with a scoreboard for decode stalls.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [REG_AW-1:0] mul_rd,
    input  logic [XLEN-1:0]   mul_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] query_rs1,
    input  logic [REG_AW-1:0] query_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [REG_AW-1:0] write_port,
    output logic [XLEN-1:0]   write_data,
    output logic              write_enable,
    output logic [NREG-1:0]   pending
);
    wb_src_t           r_last_grant;
    wb_src_t           w_grant;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_data;
    logic              w_long_grant;
    logic [REG_AW-1:0] r_write_port;
    logic [XLEN-1:0]   r_write_data;
    logic              r_write_enable;

    always_comb begin
        w_grant = reset                   ? SRC_NONE :
                  alu_valid               ? SRC_ALU  :
                  mem_valid && mul_valid  ? (r_last_grant == SRC_MEM ? SRC_MUL : SRC_MEM) :
                  mem_valid               ? SRC_MEM  :
                  mul_valid               ? SRC_MUL  : SRC_NONE;
        w_rd   = w_grant == SRC_ALU ? alu_rd   : w_grant == SRC_MEM ? mem_rd   : mul_rd;
        w_data = w_grant == SRC_ALU ? alu_data : w_grant == SRC_MEM ? mem_data : mul_data;
        w_long_grant = w_grant == SRC_MEM || w_grant == SRC_MUL;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant   <= SRC_MUL;
            r_write_enable <= 1'b0;
            r_write_port   <= '0;
            r_write_data   <= '0;
        end else begin
            if (w_long_grant) r_last_grant <= w_grant;
            r_write_enable <= w_grant != SRC_NONE && w_rd != '0;
            if (w_grant != SRC_NONE) begin
                r_write_port <= w_rd;
                r_write_data <= w_data;
            end
        end
    end

    assign mem_ready    = w_grant == SRC_MEM;
    assign mul_ready    = w_grant == SRC_MUL;
    assign write_port   = r_write_port;
    assign write_data   = r_write_data;
    assign write_enable = r_write_enable;

    wb_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .i_set_valid (issue_valid),
        .i_set_rd    (issue_rd),
        .i_clr_valid (w_long_grant),
        .i_clr_rd    (w_rd),
        .i_wr_enable (r_write_enable),
        .i_wr_port   (r_write_port),
        .i_rs1       (query_rs1),
        .i_rs2       (query_rs2),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_pending   (pending)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a write-back queue drained by a monitor on write_enable.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              alu_valid = 1'b0, mem_valid = 1'b0, mul_valid = 1'b0, issue_valid = 1'b0;
    logic [REG_AW-1:0] alu_rd = '0, mem_rd = '0, mul_rd = '0, issue_rd = '0;
    logic [REG_AW-1:0] query_rs1 = '0, query_rs2 = '0;
    logic [XLEN-1:0]   alu_data = '0, mem_data = '0, mul_data = '0;
    logic              mem_ready, mul_ready, rs1_busy, rs2_busy, write_enable;
    logic [REG_AW-1:0] write_port;
    logic [XLEN-1:0]   write_data;
    logic [NREG-1:0]   pending;

    logic [REG_AW+XLEN-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    wb_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd), .mul_data(mul_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_port(write_port), .write_data(write_data), .write_enable(write_enable),
        .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // A write presented while reset is high is cancelled and never commits.
    always @(negedge clock) begin
        if (!reset && write_enable) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got port=%0d data=%0h expected none", write_port, write_data);
            end else begin
                logic [REG_AW+XLEN-1:0] e;
                e = exp_q.pop_front();
                if ({write_port, write_data} !== e) begin
                    bad++;
                    $display("FAIL write: got port=%0d data=%0h expected port=%0d data=%0h",
                             write_port, write_data, e[REG_AW+XLEN-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
    end

    initial begin
        step(); step();
        chk("reset_we", write_enable, 0);
        chk("reset_pending", pending, 0);
        chk("reset_port", write_port, 0);
        chk("reset_ready", {mem_ready, mul_ready}, 0);
        reset = 1'b0;

        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
        mul_valid = 1; mul_rd = 4; mul_data = 32'h22;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        #1 chk("alu_blocks_ready", {mem_ready, mul_ready}, 0);
        step();
        alu_valid = 0;
        chk("alu_we", write_enable, 1);
        chk("alu_port", write_port, 5);
        chk("alu_pending", pending, 0);

        exp_q.push_back({5'd3, 32'h11});
        #1 chk("rr_first_mem", {mem_ready, mul_ready}, 2'b10);
        step();
        mem_rd = 6; mem_data = 32'h66;
        exp_q.push_back({5'd4, 32'h22});
        #1 chk("rr_then_mul", {mem_ready, mul_ready}, 2'b01);
        step();
        mul_rd = 8; mul_data = 32'h88;

        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'hA0 + i;
            exp_q.push_back({5'(10 + i), 32'hA0 + i});
            #1 chk("alu_stall_ready", {mem_ready, mul_ready}, 0);
            step();
        end
        alu_valid = 0;
        exp_q.push_back({5'd6, 32'h66});
        #1 chk("rr_after_stall_mem", {mem_ready, mul_ready}, 2'b10);
        step();
        mem_valid = 0;
        exp_q.push_back({5'd8, 32'h88});
        #1 chk("mul_alone", {mem_ready, mul_ready}, 2'b01);
        step();
        mul_valid = 0;

        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0; query_rs1 = 7;
        #1 chk("sb_busy_pending", rs1_busy, 1);
        chk("sb_pending7", pending[7], 1);
        mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
        #1 chk("sb_mem_ready", mem_ready, 1);
        step();
        mem_valid = 0;
        chk("sb_busy_inflight", rs1_busy, 1);
        chk("sb_pending7_clr", pending[7], 0);
        step();
        chk("sb_busy_done", rs1_busy, 0);

        issue_valid = 1; issue_rd = 9;
        step();
        mul_valid = 1; mul_rd = 9; mul_data = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        #1 chk("setclr_mul_ready", mul_ready, 1);
        step();
        mul_valid = 0; issue_valid = 0; query_rs2 = 9;
        chk("setclr_pending9", pending, 32'h200);
        chk("setclr_we", {write_enable, write_port}, {1'b1, 5'd9});
        #1 chk("setclr_busy", rs2_busy, 1);

        mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFFFFFF;
        #1 chk("rd0_mem_ready", mem_ready, 1);
        step();
        mem_valid = 0;
        chk("rd0_we", write_enable, 0);
        chk("rd0_data", write_data, 32'hFFFFFFFF);
        issue_valid = 1; issue_rd = 0;
        step();
        issue_valid = 0; query_rs2 = 0;
        chk("rd0_pending", pending, 32'h200);
        #1 chk("rd0_busy", rs2_busy, 0);

        mul_valid = 1; mul_rd = 13; mul_data = 32'h1313;
        step();
        mul_valid = 0; reset = 1; mem_valid = 1; mem_rd = 2;
        #1 chk("reset_ready_low", {mem_ready, mul_ready}, 0);
        step();
        chk("midreset_we", write_enable, 0);
        chk("midreset_pending", pending, 0);
        reset = 0; mem_valid = 0;
        step();
        chk("post_reset_we", write_enable, 0);
        step();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
